load_store_unit: RTL

//  Memory-access stage directly downstream of the address generator: takes the computed

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per instruction, with lane steering and load extension.
// Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
`ifndef DataBusBits
`define DataBusBits 32
`endif

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned DW = `DataBusBits
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ready,
  input  logic [DW-1:0] address,
  input  logic [DW-1:0] instruction,
  input  logic [DW-1:0] store_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] load_data,
  output logic          done,
  output logic          fault
);

  localparam int unsigned CW = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_n;
  logic [2:0]    f3_q, f3_n;
  logic [1:0]    off_q, off_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ready_n, mem_req_n, mem_we_n, done_n, fault_n;
  logic [DW-1:0] mem_addr_n, mem_wdata_n, load_data_n;
  logic [3:0]    mem_be_n;

  logic [6:0]    opcode;
  logic [2:0]    f3;
  logic          is_load, is_store, f3_ok;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c;
  logic          unused_instr;

  assign unused_instr = ^{instruction[DW-1:15], instruction[11:7]};

  // Decode and lane steering of the incoming request
  always_comb begin
    opcode   = instruction[6:0];
    f3       = instruction[14:12];
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    f3_ok    = is_load ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (f3 < 3'b011);
    case (f3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << address[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = address[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((f3[1:0] == 2'b01) && address[0]) ||
                    ((f3[1:0] == 2'b10) && (address[1:0] != 2'b00));
`endif

  function automatic logic [DW-1:0] extend(input logic [2:0] f, input logic [1:0] off,
                                           input logic [DW-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{(DW-8){b[7]}}, b};
      3'b100:  return {{(DW-8){1'b0}}, b};
      3'b001:  return {{(DW-16){h[15]}}, h};
      3'b101:  return {{(DW-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    ready_n     = ready;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_be_n    = mem_be;
    mem_wdata_n = mem_wdata;
    load_data_n = load_data;
    done_n      = 1'b0;
    fault_n     = 1'b0;
    f3_n        = f3_q;
    off_n       = off_q;
    cnt_n       = cnt_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (!(is_load || is_store)) begin
            state_n     = RESP;
            done_n      = 1'b1;
            load_data_n = '0;
          end else if (!f3_ok) begin
            state_n     = RESP;
            done_n      = 1'b1;
            fault_n     = 1'b1;
            load_data_n = '0;
          end
`ifdef MISALIGN_TRAP_EN
          else if (misalign) begin
            state_n     = RESP;
            done_n      = 1'b1;
            fault_n     = 1'b1;
            load_data_n = '0;
          end
`endif
          else begin
            state_n     = REQ;
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_addr_n  = {address[DW-1:2], 2'b00};
            mem_be_n    = be_c;
            mem_wdata_n = wdata_c;
            f3_n        = f3;
            off_n       = address[1:0];
            cnt_n       = '0;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_n     = RESP;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          done_n      = 1'b1;
          load_data_n = mem_we ? '0 : extend(f3_q, off_q, mem_rdata);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          state_n     = RESP;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          done_n      = 1'b1;
          fault_n     = 1'b1;
          load_data_n = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      ready     <= ready_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_be    <= mem_be_n;
      mem_wdata <= mem_wdata_n;
      load_data <= load_data_n;
      done      <= done_n;
      fault     <= fault_n;
      f3_q      <= f3_n;
      off_q     <= off_n;
      cnt_q     <= cnt_n;
    end
  end

endmodule
